// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a small instruction FIFO.
// Redirects flush the FIFO and drop responses to requests already in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] opcode,
    output logic [31:0] opcode_pc,
    output logic        opcode_valid,
    input  logic        opcode_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LP_DEPTH  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] LP_ONE    = CW'(1);
    localparam logic [PW-1:0] LP_PONE   = PW'(1);
    localparam logic [31:0]   LP_RST_PC = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic          r_run;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_data [DEPTH];
    logic [31:0]   r_pc   [DEPTH];

    logic [CW:0]   w_total;
    logic [CW-1:0] w_outst_nxt;
    logic [31:0]   w_redir_tgt;
    logic          w_fire;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;

    // Occupancy plus in-flight requests bounds issue, so the FIFO never overflows.
    assign w_total        = {1'b0, r_occ} + {1'b0, r_outst};
    assign imem_req_valid = r_run && !redirect_valid && (w_total < LP_DEPTH);
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_redir_tgt    = redirect_pc & 32'hFFFF_FFFC;

    // A response with nothing outstanding is stale (e.g. from before reset).
    assign w_resp = imem_resp_valid && (r_outst != '0);
    assign w_drop = redirect_valid || (r_discard != '0);
    assign w_push = w_resp && !w_drop;

    assign opcode_valid = (r_occ != '0);
    assign w_pop        = opcode_valid && opcode_ready && !redirect_valid;
    assign opcode       = r_data[r_head];
    assign opcode_pc    = r_pc[r_head];

    // Outstanding count after this cycle's request and response transfers.
    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_fire, w_resp})
            2'b10:   w_outst_nxt = r_outst + LP_ONE;
            2'b01:   w_outst_nxt = r_outst - LP_ONE;
            default: w_outst_nxt = r_outst;
        endcase
    end

    // Issue enable: first request goes out the edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // Fetch address: redirect wins, otherwise advance on each accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= LP_RST_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redir_tgt;
        end else if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Address of the next kept response; after a redirect every older
    // request is discarded, so the next kept one is the redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_pc <= LP_RST_PC;
        end else if (redirect_valid) begin
            r_resp_pc <= w_redir_tgt;
        end else if (w_push) begin
            r_resp_pc <= r_resp_pc + 32'd4;
        end
    end

    // In-flight request count and how many of them are to be thrown away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst   <= '0;
            r_discard <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_valid) begin
                r_discard <= w_outst_nxt;
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - LP_ONE;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else if (redirect_valid) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push && !w_pop) begin
                r_occ <= r_occ + LP_ONE;
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - LP_ONE;
            end
            if (w_push) begin
                r_tail <= r_tail + LP_PONE;
            end
            if (w_pop) begin
                r_head <= r_head + LP_PONE;
            end
        end
    end

    // FIFO storage: instruction word and its fetch address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_data[r_tail] <= imem_resp_data;
            r_pc[r_tail]   <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with an in-order echo memory
// (data = address), covering streaming, backpressure, redirect, wrap, reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] opcode;
    logic [31:0] opcode_pc;
    logic        opcode_valid;
    logic        opcode_ready;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .opcode         (opcode),
        .opcode_pc      (opcode_pc),
        .opcode_valid   (opcode_valid),
        .opcode_ready   (opcode_ready)
    );

    typedef struct packed {
        logic        rr;
        logic        ordy;
        logic        rv;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] op;
    } vec_t;

    vec_t        tbl [17];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          fires   = 0;
    logic [31:0] memq   [$];
    logic [31:0] pop_pc [$];
    logic [31:0] pop_op [$];
    logic        mem_en     = 1'b0;
    logic        force_rv   = 1'b0;
    logic [31:0] force_data = '0;
    logic        s_fire;
    logic        s_resp;
    logic [31:0] s_addr;

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive memory response for this cycle, settle, sample.
    task automatic cyc_begin();
        s_resp = 1'b0;
        if (force_rv) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = force_data;
        end else if (mem_en && memq.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memq[0];
            s_resp          = 1'b1;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        s_fire = imem_req_valid && imem_req_ready;
        s_addr = imem_req_addr;
        if (opcode_valid && opcode_ready && !redirect_valid) begin
            pop_pc.push_back(opcode_pc);
            pop_op.push_back(opcode);
        end
    endtask

    task automatic cyc_end();
        @(posedge clk);
        if (s_resp) void'(memq.pop_front());
        if (s_fire) begin
            memq.push_back(s_addr);
            fires++;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        cyc_begin();
        cyc_end();
    endtask

    task automatic do_reset(input string name);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        opcode_ready   = 1'b0;
        mem_en         = 1'b0;
        force_rv       = 1'b0;
        memq.delete();
        cyc_begin();
        chk1({name, " rst req_valid"}, imem_req_valid, 1'b0);
        chk1({name, " rst opcode_valid"}, opcode_valid, 1'b0);
        chk32({name, " rst opcode"}, opcode, 32'h0);
        chk32({name, " rst opcode_pc"}, opcode_pc, 32'h0);
        chk32({name, " rst req_addr"}, imem_req_addr, 32'h0);
        cyc_end();
        tick();
        rst = 1'b0;
        pop_pc.delete();
        pop_op.delete();
        fires = 0;
    endtask

    task automatic wait_pops(input int n, input string name);
        int k = 0;
        while (pop_pc.size() < n && k < 40) begin
            tick();
            k++;
        end
        n_tests++;
        if (pop_pc.size() < n) begin
            n_fail++;
            $display("FAIL %s pop timeout: got %0d pops expected %0d",
                     name, pop_pc.size(), n);
        end
    endtask

    function automatic logic [31:0] get_pc(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] get_op(input int i);
        return (i < pop_op.size()) ? pop_op[i] : 32'hDEAD_DEAD;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rr, ordy, exp req_valid, exp addr, exp opcode_valid, exp opcode
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h18};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h20};

        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        opcode_ready    = 1'b0;
        @(negedge clk);

        // Streaming and a 5-cycle request stall, cycle by cycle.
        do_reset("A");
        mem_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            imem_req_ready = tbl[i].rr;
            opcode_ready   = tbl[i].ordy;
            cyc_begin();
            chk1($sformatf("A%0d req_valid", i), imem_req_valid, tbl[i].rv);
            chk32($sformatf("A%0d req_addr", i), imem_req_addr, tbl[i].addr);
            chk1($sformatf("A%0d opcode_valid", i), opcode_valid, tbl[i].ov);
            if (tbl[i].ov) begin
                chk32($sformatf("A%0d opcode", i), opcode, tbl[i].op);
                chk32($sformatf("A%0d opcode_pc", i), opcode_pc, tbl[i].op);
            end
            cyc_end();
        end

        // Decode stalled: exactly DEPTH requests, then in-order drain.
        do_reset("B");
        mem_en         = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        cyc_begin();
        chk32("B fire count", 32'(fires), 32'd4);
        chk1("B req_valid full", imem_req_valid, 1'b0);
        cyc_end();
        opcode_ready = 1'b1;
        wait_pops(6, "B");
        for (int i = 0; i < 6; i++) begin
            chk32($sformatf("B pop%0d pc", i), get_pc(i), 32'(i * 4));
            chk32($sformatf("B pop%0d op", i), get_op(i), 32'(i * 4));
        end

        // Redirect with two requests in flight.
        do_reset("C");
        imem_req_ready = 1'b1;
        opcode_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        imem_req_ready = 1'b0;
        cyc_begin();
        chk32("C held addr", imem_req_addr, 32'h18);
        cyc_end();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        cyc_begin();
        chk1("C req_valid in redirect", imem_req_valid, 1'b0);
        cyc_end();
        redirect_valid = 1'b0;
        mem_en         = 1'b1;
        cyc_begin();
        chk1("C req_valid after", imem_req_valid, 1'b1);
        chk32("C addr after", imem_req_addr, 32'h100);
        cyc_end();
        wait_pops(1, "C");
        chk32("C first opcode_pc", get_pc(0), 32'h100);
        chk32("C first opcode", get_op(0), 32'h100);

        // Address wrap, then back-to-back redirects.
        do_reset("D");
        mem_en         = 1'b1;
        imem_req_ready = 1'b1;
        opcode_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        cyc_begin();
        chk32("D addr top", imem_req_addr, 32'hFFFF_FFFC);
        cyc_end();
        cyc_begin();
        chk32("D addr wrap", imem_req_addr, 32'h0);
        cyc_end();
        wait_pops(2, "D");
        chk32("D pop0 pc", get_pc(0), 32'hFFFF_FFFC);
        chk32("D pop1 pc", get_pc(1), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_pc    = 32'h30F;
        tick();
        redirect_valid = 1'b0;
        pop_pc.delete();
        pop_op.delete();
        cyc_begin();
        chk1("D b2b opcode_valid", opcode_valid, 1'b0);
        chk32("D b2b addr", imem_req_addr, 32'h30C);
        cyc_end();
        wait_pops(1, "D b2b");
        chk32("D b2b opcode_pc", get_pc(0), 32'h30C);
        chk32("D b2b opcode", get_op(0), 32'h30C);

        // Reset mid-operation with 3 in flight, then stale responses.
        do_reset("E");
        imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        mem_en = 1'b1;
        tick();
        mem_en = 1'b0;
        cyc_begin();
        chk1("E pre opcode_valid", opcode_valid, 1'b1);
        chk32("E pre addr", imem_req_addr, 32'h10);
        rst = 1'b1;
        #1;
        chk1("E async req_valid", imem_req_valid, 1'b0);
        chk1("E async opcode_valid", opcode_valid, 1'b0);
        chk32("E async opcode", opcode, 32'h0);
        chk32("E async opcode_pc", opcode_pc, 32'h0);
        chk32("E async addr", imem_req_addr, 32'h0);
        cyc_end();
        memq.delete();
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        force_rv       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            force_data = 32'hBAD0_0000 + 32'(i);
            tick();
        end
        force_rv = 1'b0;
        cyc_begin();
        chk1("E stale opcode_valid", opcode_valid, 1'b0);
        chk1("E restart req_valid", imem_req_valid, 1'b1);
        chk32("E restart addr", imem_req_addr, 32'h0);
        cyc_end();
        imem_req_ready = 1'b1;
        opcode_ready   = 1'b1;
        mem_en         = 1'b1;
        wait_pops(1, "E");
        chk32("E first opcode_pc", get_pc(0), 32'h0);
        chk32("E first opcode", get_op(0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
